i2c_target: RTL and testbench

- I2C target (slave) endpoint; the far end of the bus from the team's master-side SCL/data-clock generator.
- Oversamples SCL/SDA on the 100 MHz system clock, detects START/STOP, matches a fixed 7-bit address, and ACKs.
- Delivers written bytes to fabric and serves read bytes from fabric.
- Drives the bus open-drain only: an output enable pulls SDA low.

---
 rtl/i2c_target.sv | 263 ++++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target endpoint: filtered SCL/SDA, START/STOP detection, fixed-address match, byte write/read.
// Optional clock stretching after each written byte: define I2C_TARGET_CLK_STRETCH_EN.
module i2c_target #(
    parameter logic [6:0] ADDR       = 7'h42,
    parameter int         FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
`ifdef I2C_TARGET_CLK_STRETCH_EN
    ,
    output logic       scl_oe,
    input  logic       rx_ready
`endif
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR       = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD       = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } state_t;

    // index 1 = SCL, index 0 = SDA
    logic [1:0]    sync1_r, sync2_r, filt_r, dly_r;
    logic [CW-1:0] cnt_r [2];

    state_t     state_r, state_n;
    logic [3:0] bit_cnt_r, bit_cnt_n;
    logic [7:0] shreg_r, shreg_n, tx_sh_r, tx_sh_n, rx_data_r, rx_data_n;
    logic       rw_r, rw_n, sda_oe_r, sda_oe_n, rx_valid_r, rx_valid_n;
    logic       tx_req_r, tx_req_n, busy_r, busy_n;
    logic       start_r, start_n, stop_r, stop_n;
    logic       scl_f_s, sda_f_s, start_ev_s, stop_ev_s, sample_ev_s, shift_ev_s;

    // Synchronize both lines, then accept a new level only after it holds FILTER_LEN clks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 2'b11;
            sync2_r <= 2'b11;
            filt_r  <= 2'b11;
            dly_r   <= 2'b11;
            for (int i = 0; i < 2; i++) cnt_r[i] <= {CW{1'b0}};
        end else begin
            sync1_r <= {scl_in, sda_in};
            sync2_r <= sync1_r;
            dly_r   <= filt_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] != filt_r[i]) begin
                    if (cnt_r[i] == CW'(FILTER_LEN - 1)) begin
                        filt_r[i] <= sync2_r[i];
                        cnt_r[i]  <= {CW{1'b0}};
                    end else begin
                        cnt_r[i] <= cnt_r[i] + CW'(1);
                    end
                end else begin
                    cnt_r[i] <= {CW{1'b0}};
                end
            end
        end
    end

    assign scl_f_s     = filt_r[1];
    assign sda_f_s     = filt_r[0];
    assign start_ev_s  = scl_f_s & dly_r[1] & dly_r[0] & ~sda_f_s;
    assign stop_ev_s   = scl_f_s & dly_r[1] & ~dly_r[0] & sda_f_s;
    assign sample_ev_s = scl_f_s & ~dly_r[1];
    assign shift_ev_s  = ~scl_f_s & dly_r[1];

    // Protocol state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            shreg_r    <= 8'h00;
            tx_sh_r    <= 8'h00;
            rx_data_r  <= 8'h00;
            rw_r       <= 1'b0;
            sda_oe_r   <= 1'b0;
            rx_valid_r <= 1'b0;
            tx_req_r   <= 1'b0;
            busy_r     <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            bit_cnt_r  <= bit_cnt_n;
            shreg_r    <= shreg_n;
            tx_sh_r    <= tx_sh_n;
            rx_data_r  <= rx_data_n;
            rw_r       <= rw_n;
            sda_oe_r   <= sda_oe_n;
            rx_valid_r <= rx_valid_n;
            tx_req_r   <= tx_req_n;
            busy_r     <= busy_n;
            start_r    <= start_n;
            stop_r     <= stop_n;
        end
    end

    // Next-state logic; SDA only moves on shift edges apart from START/STOP/en.
    always_comb begin
        state_n    = state_r;
        bit_cnt_n  = bit_cnt_r;
        shreg_n    = shreg_r;
        tx_sh_n    = tx_sh_r;
        rx_data_n  = rx_data_r;
        rw_n       = rw_r;
        sda_oe_n   = sda_oe_r;
        rx_valid_n = 1'b0;
        tx_req_n   = 1'b0;
        busy_n     = busy_r;
        start_n    = 1'b0;
        stop_n     = 1'b0;
        if (!en) begin
            state_n   = ST_IDLE;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            bit_cnt_n = 4'd0;
        end else if (start_ev_s) begin
            start_n   = 1'b1;
            sda_oe_n  = 1'b0;
            bit_cnt_n = 4'd0;
            state_n   = ST_ADDR;
            busy_n    = 1'b1;
        end else if (stop_ev_s) begin
            stop_n   = 1'b1;
            sda_oe_n = 1'b0;
            state_n  = ST_IDLE;
            busy_n   = 1'b0;
        end else begin
            case (state_r)
                ST_ADDR, ST_WR: begin
                    if (sample_ev_s && bit_cnt_r != 4'd8) begin
                        shreg_n   = {shreg_r[6:0], sda_f_s};
                        bit_cnt_n = bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd7 && state_r == ST_ADDR) begin
                            rw_n = sda_f_s;
                            if (shreg_r[6:0] != ADDR) begin
                                state_n = ST_IGNORE;
                                busy_n  = 1'b0;
                            end else begin
                                state_n = ST_ADDR;
                            end
                        end else if (bit_cnt_r == 4'd7) begin
                            rx_data_n  = {shreg_r[6:0], sda_f_s};
                            rx_valid_n = 1'b1;
                        end else begin
                            state_n = state_r;
                        end
                    end else if (shift_ev_s && bit_cnt_r == 4'd8) begin
                        sda_oe_n  = 1'b1;
                        bit_cnt_n = 4'd0;
                        state_n   = (state_r == ST_ADDR) ? ST_ADDR_ACK : ST_WR_ACK;
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_ADDR_ACK: begin
                    if (sample_ev_s) begin
                        tx_req_n = rw_r;
                    end else if (shift_ev_s && rw_r) begin
                        sda_oe_n  = ~tx_data[7];
                        tx_sh_n   = {tx_data[6:0], 1'b0};
                        bit_cnt_n = 4'd1;
                        state_n   = ST_RD;
                    end else if (shift_ev_s) begin
                        sda_oe_n = 1'b0;
                        state_n  = ST_WR;
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_WR_ACK: begin
                    if (shift_ev_s) begin
                        sda_oe_n = 1'b0;
                        state_n  = ST_WR;
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_RD: begin
                    if (shift_ev_s && bit_cnt_r == 4'd8) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = 4'd0;
                        state_n   = ST_RD_ACK;
                    end else if (shift_ev_s) begin
                        sda_oe_n  = ~tx_sh_r[7];
                        tx_sh_n   = {tx_sh_r[6:0], 1'b0};
                        bit_cnt_n = bit_cnt_r + 4'd1;
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_RD_ACK: begin
                    // bit_cnt marks that the master ACKed and another byte is due
                    if (sample_ev_s && !sda_f_s) begin
                        tx_req_n  = 1'b1;
                        bit_cnt_n = 4'd1;
                    end else if (sample_ev_s) begin
                        sda_oe_n = 1'b0;
                        state_n  = ST_IGNORE;
                    end else if (shift_ev_s && bit_cnt_r == 4'd1) begin
                        sda_oe_n  = ~tx_data[7];
                        tx_sh_n   = {tx_data[6:0], 1'b0};
                        state_n   = ST_RD;
                    end else begin
                        state_n = state_r;
                    end
                end
                default: begin
                    state_n = state_r;
                end
            endcase
        end
    end

`ifdef I2C_TARGET_CLK_STRETCH_EN
    logic scl_oe_r;

    // Hold SCL low after each write ACK until the fabric can take the next byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_oe_r <= 1'b0;
        end else if (!en || start_ev_s || stop_ev_s) begin
            scl_oe_r <= 1'b0;
        end else if (state_r == ST_WR_ACK && shift_ev_s) begin
            scl_oe_r <= 1'b1;
        end else if (rx_ready) begin
            scl_oe_r <= 1'b0;
        end else begin
            scl_oe_r <= scl_oe_r;
        end
    end

    assign scl_oe = scl_oe_r;
`endif

    assign sda_oe    = sda_oe_r;
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign tx_req    = tx_req_r;
    assign busy      = busy_r;
    assign start_det = start_r;
    assign stop_det  = stop_r;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: open-drain bus master model, per-scenario check tasks.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int Q = 25;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       scl_bus, sda_bus;
    logic       sda_oe, rx_valid, tx_req, busy, start_det, stop_det;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;
`ifdef I2C_TARGET_CLK_STRETCH_EN
    logic       scl_oe;
    logic       rx_ready = 1'b1;
    int         run = 0;
    int         run_max = 0;
`endif

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         rx_cnt = 0, tx_cnt = 0, st_cnt = 0, sp_cnt = 0;
    logic [7:0] rx_log [32];

    always #5 clk = ~clk;

    assign sda_bus = m_sda & ~sda_oe;
`ifdef I2C_TARGET_CLK_STRETCH_EN
    assign scl_bus = m_scl & ~scl_oe;
`else
    assign scl_bus = m_scl;
`endif

    i2c_target dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .scl_in    (scl_bus),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .busy      (busy),
        .start_det (start_det),
        .stop_det  (stop_det)
`ifdef I2C_TARGET_CLK_STRETCH_EN
        ,
        .scl_oe    (scl_oe),
        .rx_ready  (rx_ready)
`endif
    );

    // Event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_cnt < 32) rx_log[rx_cnt] = rx_data;
            rx_cnt = rx_cnt + 1;
        end
        if (tx_req) tx_cnt = tx_cnt + 1;
        if (start_det) st_cnt = st_cnt + 1;
        if (stop_det) sp_cnt = sp_cnt + 1;
`ifdef I2C_TARGET_CLK_STRETCH_EN
        if (scl_oe) run = run + 1;
        else run = 0;
        if (run > run_max) run_max = run;
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        int n;
        wq(Q);
        m_sda = b;
        wq(Q);
        m_scl = 1'b1;
        n = 0;
        while (scl_bus !== 1'b1 && n < 20000) begin
            wq(1);
            n++;
        end
        if (n >= 20000) begin
            total_cnt++;
            $display("FAIL scl_release: scl stuck low got 0 exp 1");
        end
        wq(Q);
        s = sda_bus;
        wq(Q);
        m_scl = 1'b0;
    endtask

    task automatic bus_start();
        wq(Q); m_sda = 1'b1;
        wq(Q); m_scl = 1'b1;
        wq(Q); m_sda = 1'b0;
        wq(Q); m_scl = 1'b0;
    endtask

    task automatic bus_stop();
        wq(Q); m_sda = 1'b0;
        wq(Q); m_scl = 1'b1;
        wq(Q); m_sda = 1'b1;
        wq(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        tx_data = next_tx;
        bus_bit(nack, s);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wq(5);
        total_cnt++;
        if ({sda_oe, rx_valid, tx_req, busy, start_det, stop_det} !== 6'b000000)
            $display("FAIL reset_ctrl got %b exp 000000", {sda_oe, rx_valid, tx_req, busy, start_det, stop_det});
        else pass_cnt++;
        total_cnt++;
        if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h exp 00", rx_data);
        else pass_cnt++;
        rst_n = 1'b1;
        wq(20);
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        int r0, s0, p0;
        r0 = rx_cnt; s0 = st_cnt; p0 = sp_cnt;
        bus_start();
        write_byte(8'h84, a0);
        write_byte(8'hA5, a1);
        write_byte(8'h3C, a2);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL wr_busy got %b exp 1", busy);
        else pass_cnt++;
        bus_stop();
        wq(20);
        total_cnt++;
        if ({a0, a1, a2} !== 3'b000) $display("FAIL wr_acks got %b exp 000", {a0, a1, a2});
        else pass_cnt++;
        total_cnt++;
        if (rx_cnt - r0 !== 2) $display("FAIL wr_rx_count got %0d exp 2", rx_cnt - r0);
        else pass_cnt++;
        total_cnt++;
        if (rx_log[r0] !== 8'hA5) $display("FAIL wr_byte0 got %h exp a5", rx_log[r0]);
        else pass_cnt++;
        total_cnt++;
        if (rx_log[r0 + 1] !== 8'h3C) $display("FAIL wr_byte1 got %h exp 3c", rx_log[r0 + 1]);
        else pass_cnt++;
        total_cnt++;
        if (st_cnt - s0 !== 1 || sp_cnt - p0 !== 1)
            $display("FAIL wr_start_stop got %0d/%0d exp 1/1", st_cnt - s0, sp_cnt - p0);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL wr_busy_end got %b exp 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_read();
        logic a;
        logic [7:0] d0, d1;
        int t0;
        t0 = tx_cnt;
        tx_data = 8'h96;
        bus_start();
        write_byte(8'h85, a);
        read_byte(1'b0, 8'h0F, d0);
        read_byte(1'b1, 8'h00, d1);
        wq(20);
        total_cnt++;
        if (a !== 1'b0) $display("FAIL rd_addr_ack got %b exp 0", a);
        else pass_cnt++;
        total_cnt++;
        if (d0 !== 8'h96) $display("FAIL rd_byte0 got %h exp 96", d0);
        else pass_cnt++;
        total_cnt++;
        if (d1 !== 8'h0F) $display("FAIL rd_byte1 got %h exp 0f", d1);
        else pass_cnt++;
        total_cnt++;
        if (tx_cnt - t0 !== 2) $display("FAIL rd_tx_req_count got %0d exp 2", tx_cnt - t0);
        else pass_cnt++;
        total_cnt++;
        if (sda_oe !== 1'b0 || busy !== 1'b1)
            $display("FAIL rd_nack_release got oe=%b busy=%b exp oe=0 busy=1", sda_oe, busy);
        else pass_cnt++;
        bus_stop();
        wq(20);
    endtask

    task automatic test_mismatch();
        logic a;
        int r0;
        r0 = rx_cnt;
        bus_start();
        write_byte(8'h86, a);
        total_cnt++;
        if (a !== 1'b1) $display("FAIL mm_no_ack got %b exp 1", a);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL mm_busy got %b exp 0", busy);
        else pass_cnt++;
        write_byte(8'h55, a);
        total_cnt++;
        if (rx_cnt - r0 !== 0 || a !== 1'b1)
            $display("FAIL mm_ignored got rx=%0d ack=%b exp rx=0 ack=1", rx_cnt - r0, a);
        else pass_cnt++;
        bus_start();
        write_byte(8'h84, a);
        total_cnt++;
        if (a !== 1'b0) $display("FAIL mm_next_ack got %b exp 0", a);
        else pass_cnt++;
        bus_stop();
        wq(20);
    endtask

    task automatic test_glitch();
        int s0, p0;
        s0 = st_cnt; p0 = sp_cnt;
        m_sda = 1'b0; wq(3); m_sda = 1'b1; wq(30);
        total_cnt++;
        if (st_cnt - s0 !== 0) $display("FAIL gl_short got %0d exp 0", st_cnt - s0);
        else pass_cnt++;
        m_sda = 1'b0; wq(6); m_sda = 1'b1; wq(30);
        total_cnt++;
        if (st_cnt - s0 !== 1) $display("FAIL gl_long_start got %0d exp 1", st_cnt - s0);
        else pass_cnt++;
        total_cnt++;
        if (sp_cnt - p0 !== 1 || busy !== 1'b0)
            $display("FAIL gl_long_stop got %0d busy=%b exp 1 busy=0", sp_cnt - p0, busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic a0, a1, a2, s;
        logic [7:0] d;
        int r0, s0, r1;
        r0 = rx_cnt; s0 = st_cnt;
        tx_data = 8'h5A;
        bus_start();
        write_byte(8'h84, a0);
        write_byte(8'hA5, a1);
        bus_start();
        write_byte(8'h85, a2);
        read_byte(1'b1, 8'h00, d);
        bus_stop();
        wq(20);
        total_cnt++;
        if ({a0, a1, a2} !== 3'b000) $display("FAIL rs_acks got %b exp 000", {a0, a1, a2});
        else pass_cnt++;
        total_cnt++;
        if (st_cnt - s0 !== 2) $display("FAIL rs_start_count got %0d exp 2", st_cnt - s0);
        else pass_cnt++;
        total_cnt++;
        if (rx_cnt - r0 !== 1 || rx_log[r0] !== 8'hA5)
            $display("FAIL rs_rx got %0d/%h exp 1/a5", rx_cnt - r0, rx_log[r0]);
        else pass_cnt++;
        total_cnt++;
        if (d !== 8'h5A) $display("FAIL rs_read got %h exp 5a", d);
        else pass_cnt++;
        r1 = rx_cnt;
        bus_start();
        write_byte(8'h84, a0);
        bus_bit(1'b1, s);
        bus_bit(1'b0, s);
        bus_bit(1'b1, s);
        bus_start();
        write_byte(8'h84, a1);
        write_byte(8'h11, a2);
        bus_stop();
        wq(20);
        total_cnt++;
        if ({a0, a1, a2} !== 3'b000) $display("FAIL mid_acks got %b exp 000", {a0, a1, a2});
        else pass_cnt++;
        total_cnt++;
        if (rx_cnt - r1 !== 1 || rx_log[r1] !== 8'h11)
            $display("FAIL mid_rx got %0d/%h exp 1/11", rx_cnt - r1, rx_log[r1]);
        else pass_cnt++;
    endtask

    task automatic test_enable();
        logic a;
        bus_start();
        write_byte(8'h84, a);
        total_cnt++;
        if (busy !== 1'b1 || a !== 1'b0) $display("FAIL en_pre got busy=%b ack=%b exp 1/0", busy, a);
        else pass_cnt++;
        en = 1'b0;
        wq(2);
        total_cnt++;
        if (busy !== 1'b0 || sda_oe !== 1'b0) $display("FAIL en_off got busy=%b oe=%b exp 0/0", busy, sda_oe);
        else pass_cnt++;
        bus_stop();
        en = 1'b1;
        wq(20);
    endtask

`ifdef I2C_TARGET_CLK_STRETCH_EN
    task automatic test_stretch();
        logic a0, a1, a2;
        int r0;
        r0 = rx_cnt;
        bus_start();
        write_byte(8'h84, a0);
        rx_ready = 1'b0;
        write_byte(8'h77, a1);
        wq(5010);
        total_cnt++;
        if (scl_oe !== 1'b1 || run_max < 5000)
            $display("FAIL st_hold got oe=%b run=%0d exp 1 >=5000", scl_oe, run_max);
        else pass_cnt++;
        rx_ready = 1'b1;
        wq(1);
        total_cnt++;
        if (scl_oe !== 1'b0) $display("FAIL st_release got %b exp 0", scl_oe);
        else pass_cnt++;
        write_byte(8'h12, a2);
        bus_stop();
        wq(20);
        total_cnt++;
        if ({a0, a1, a2} !== 3'b000 || rx_cnt - r0 !== 2 || rx_log[r0] !== 8'h77 || rx_log[r0 + 1] !== 8'h12)
            $display("FAIL st_xfer got acks=%b n=%0d %h %h exp 000 2 77 12",
                     {a0, a1, a2}, rx_cnt - r0, rx_log[r0], rx_log[r0 + 1]);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_glitch();
        test_back_to_back();
        test_enable();
`ifdef I2C_TARGET_CLK_STRETCH_EN
        test_stretch();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
